// File: rtl/countdown_timer_mmss.sv
// countdown_timer_mmss
// MM:SS down-counting timer with four BCD digits. It loads a clamped preset,
// decrements once per 1 Hz tick while running, and raises a one-cycle done
// pulse plus a held alarm level when the count reaches 00:00.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | stopped; count holds the preset, or 00:00 after clear/reset
//   S_RUN     | counting down by one second on each tick
//   S_PAUSED  | counting suspended; start resumes from the held count
//   S_EXPIRED | count reached 00:00 while running; alarm held high
module countdown_timer_mmss (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic       start_i,
  input  logic       pause_i,
  input  logic [3:0] ld_min_tens_i,
  input  logic [3:0] ld_min_ones_i,
  input  logic [3:0] ld_sec_tens_i,
  input  logic [3:0] ld_sec_ones_i,
  output logic [3:0] min_tens_o,
  output logic [3:0] min_ones_o,
  output logic [3:0] sec_tens_o,
  output logic [3:0] sec_ones_o,
  output logic       running_o,
  output logic       done_o,
  output logic       alarm_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] min_tens_q, min_tens_d;
  logic [3:0] min_ones_q, min_ones_d;
  logic [3:0] sec_tens_q, sec_tens_d;
  logic [3:0] sec_ones_q, sec_ones_d;
  logic       done_q, done_d;

  logic [3:0] dec_min_tens, dec_min_ones, dec_sec_tens, dec_sec_ones;
  logic       count_zero, count_one;
  logic       start_ok;

  // Tens digits of both minutes and seconds top out at 5.
  function automatic logic [3:0] clamp_tens(input logic [3:0] v);
    return (v > 4'd5) ? 4'd5 : v;
  endfunction

  // Ones digits top out at 9.
  function automatic logic [3:0] clamp_ones(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  // Count classification used by start qualification and expiry detection.
  always_comb begin
    count_zero = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                 (sec_tens_q == 4'd0) && (sec_ones_q == 4'd0);
    count_one  = (min_tens_q == 4'd0) && (min_ones_q == 4'd0) &&
                 (sec_tens_q == 4'd0) && (sec_ones_q == 4'd1);
    start_ok   = ((state_q == S_IDLE) || (state_q == S_PAUSED)) && !count_zero;
  end

  // One-second decrement with borrow rippling sec_ones -> sec_tens -> min_ones -> min_tens.
  always_comb begin
    dec_min_tens = min_tens_q;
    dec_min_ones = min_ones_q;
    dec_sec_tens = sec_tens_q;
    dec_sec_ones = sec_ones_q;
    if (sec_ones_q != 4'd0) begin
      dec_sec_ones = sec_ones_q - 4'd1;
    end else begin
      dec_sec_ones = 4'd9;
      if (sec_tens_q != 4'd0) begin
        dec_sec_tens = sec_tens_q - 4'd1;
      end else begin
        dec_sec_tens = 4'd5;
        if (min_ones_q != 4'd0) begin
          dec_min_ones = min_ones_q - 4'd1;
        end else begin
          dec_min_ones = 4'd9;
          // Only reached when the count is non-zero, so min_tens is at least 1.
          dec_min_tens = min_tens_q - 4'd1;
        end
      end
    end
  end

  // Next-state and next-count selection in priority order clear > load > start > pause > tick.
  always_comb begin
    state_d    = state_q;
    min_tens_d = min_tens_q;
    min_ones_d = min_ones_q;
    sec_tens_d = sec_tens_q;
    sec_ones_d = sec_ones_q;
    done_d     = 1'b0;

    if (clear_i) begin
      state_d    = S_IDLE;
      min_tens_d = 4'd0;
      min_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      sec_ones_d = 4'd0;
    end else if (load_i && (state_q != S_RUN)) begin
      state_d    = S_IDLE;
      min_tens_d = clamp_tens(ld_min_tens_i);
      min_ones_d = clamp_ones(ld_min_ones_i);
      sec_tens_d = clamp_tens(ld_sec_tens_i);
      sec_ones_d = clamp_ones(ld_sec_ones_i);
    end else if (start_i) begin
      // A start that is not accepted still masks pause and tick on this edge.
      if (start_ok) begin
        state_d = S_RUN;
      end
    end else if (pause_i) begin
      if (state_q == S_RUN) begin
        state_d = S_PAUSED;
      end
    end else if (tick_i && !load_i && (state_q == S_RUN) && !count_zero) begin
      min_tens_d = dec_min_tens;
      min_ones_d = dec_min_ones;
      sec_tens_d = dec_sec_tens;
      sec_ones_d = dec_sec_ones;
      if (count_one) begin
        state_d = S_EXPIRED;
        done_d  = 1'b1;
      end
    end
  end

  // State, count and done-pulse registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      min_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      sec_ones_q <= 4'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      min_tens_q <= min_tens_d;
      min_ones_q <= min_ones_d;
      sec_tens_q <= sec_tens_d;
      sec_ones_q <= sec_ones_d;
      done_q     <= done_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    min_tens_o = min_tens_q;
    min_ones_o = min_ones_q;
    sec_tens_o = sec_tens_q;
    sec_ones_o = sec_ones_q;
    running_o  = (state_q == S_RUN);
    alarm_o    = (state_q == S_EXPIRED);
    done_o     = done_q;
  end

endmodule

// File: doc/countdown_timer_mmss.md
# countdown_timer_mmss

Down-counting MM:SS timer, the countdown counterpart of the stopwatch's up-counting digit chain. It holds four BCD digits (minutes tens/ones, seconds tens/ones) and loads a preset time. While running it decrements once per `tick` enable, borrowing across digits, and raises `done`/`alarm` on reaching 00:00. It sits beside the stopwatch counters and drives the same seven-segment display path.

## Interface
- No parameters; digit ranges are fixed: minutes 00–59, seconds 00–59.
- `clk` input 1: system clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high reset.
- `tick` input 1: one-cycle 1 Hz enable from the shared prescaler.
- `clear` input 1: force count to 00:00 and return to IDLE.
- `load` input 1: load the preset digits.
- `start` input 1: begin or resume counting.
- `pause` input 1: suspend counting.
- `ld_min_tens`, `ld_min_ones`, `ld_sec_tens`, `ld_sec_ones` input 4 each: BCD preset values.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones` output 4 each: current BCD count, registered.
- `running` output 1: high while in RUN.
- `done` output 1: single-cycle pulse on expiry.
- `alarm` output 1: level, high while in EXPIRED.

## Operation
- States: IDLE, RUN, PAUSED, EXPIRED.
- Input priority, evaluated each edge: reset > clear > load > start > pause > tick.
- reset:
  - all digits 0, state IDLE.
  - `running`=0, `done`=0, `alarm`=0.
- clear, in any state:
  - digits 0, state IDLE.
  - `done`=0.
- load:
  - Accepted in IDLE, PAUSED and EXPIRED; ignored in RUN.
  - Digits take the clamped preset. Ones digits above 9 clamp to 9. Tens digits above 5 clamp to 5.
  - State becomes IDLE.
- start:
  - From IDLE or PAUSED with count ≠ 00:00: go to RUN.
  - With count = 00:00: ignored, state unchanged.
  - Ignored in RUN and EXPIRED.
- pause: RUN → PAUSED; ignored in other states.
- tick in RUN, when no higher-priority input is asserted, decrements the count by one second:
  - `sec_ones` 0 → 9 with borrow; otherwise minus 1.
  - On borrow, `sec_tens` 0 → 5 with borrow; otherwise minus 1.
  - On borrow, `min_ones` 0 → 9 with borrow; otherwise minus 1.
  - On borrow, `min_tens` minus 1.
  - 00:00 is never decremented.
- Expiry: a tick in RUN with count 00:01 makes the digits 00:00, moves the state to EXPIRED, and asserts `done` for exactly that one cycle.
- EXPIRED: `alarm`=1 and digits hold 00:00 until load, clear or reset.
- tick outside RUN: no effect.

## Timing
- All outputs are registered and reflect state one cycle after the sampling edge.
- Decrement latency is 1 cycle: the tick sampled at edge N is visible on the digits after edge N.
- Same-edge combinations:
  - start+tick in IDLE/PAUSED: enters RUN with no decrement; the first decrement is on the next tick.
  - pause+tick in RUN: enters PAUSED with no decrement.
  - load+start in PAUSED: load wins; state IDLE, count = preset.
  - clear during the expiry tick: clear wins; no `done` pulse.
- `done` is high only on the cycle the state first shows EXPIRED. `alarm` rises on the same cycle and stays high.
- `running` is combinationally equal to (state == RUN) of the registered state.
- reset asserted mid-count returns to the reset values on the next edge regardless of other inputs.

## Test plan
- reset, load 01:00, start, one tick -> digits 00:59; `running`=1.
- load 10:00, start, one tick -> 09:59 (full three-level borrow).
- load 00:02, start, two ticks -> after the 2nd tick digits 00:00, `done`=1 for one cycle, `alarm`=1 held, `running`=0; further ticks and start -> no change.
- load 05:30, start, 3 ticks, pause+tick same cycle, 2 more ticks -> 05:27 in PAUSED; start, 1 tick -> 05:26.
- load 7,9,8,12 (min_tens, min_ones, sec_tens, sec_ones) -> digits 5,9,5,9; load 00:00 then start -> stays IDLE, `running`=0.
- load 00:01, start, clear asserted with tick -> 00:00, IDLE, `done` never asserted; reset mid-RUN at 03:15 -> 00:00, all flags 0 next cycle.
